// File: rtl/tlm_mmio_slave_if.sv
// Memory-mapped request/response bus between a CPU-side master and the
// counter block. Signal names carry the block's _i/_o orientation so the
// slave side reads naturally; the master modport is the mirror image.
//
// Handshake: a request exists when mem_rd_i=1 or mem_wr_i!=0. It is taken in
// the cycle where it exists and mem_accept_o=1. Exactly one cycle later
// mem_ack_o pulses for one cycle with mem_data_rd_o, mem_error_o and
// mem_resp_tag_o valid. Only one request is ever outstanding.
interface tlm_mmio_slave_if;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_wr_i;
    logic        mem_rd_i;
    logic [3:0]  mem_wr_i;
    logic [10:0] mem_req_tag_i;
    logic [31:0] mem_data_rd_o;
    logic        mem_accept_o;
    logic        mem_ack_o;
    logic        mem_error_o;
    logic [10:0] mem_resp_tag_o;

    modport master (
        output mem_addr_i,
        output mem_data_wr_i,
        output mem_rd_i,
        output mem_wr_i,
        output mem_req_tag_i,
        input  mem_data_rd_o,
        input  mem_accept_o,
        input  mem_ack_o,
        input  mem_error_o,
        input  mem_resp_tag_o
    );

    modport slave (
        input  mem_addr_i,
        input  mem_data_wr_i,
        input  mem_rd_i,
        input  mem_wr_i,
        input  mem_req_tag_i,
        output mem_data_rd_o,
        output mem_accept_o,
        output mem_ack_o,
        output mem_error_o,
        output mem_resp_tag_o
    );
endinterface

// File: rtl/tlm_mmio_slave.sv
// Performance-counter MMIO slave: three free-running 64-bit counters
// (cycles, retired instructions, stall cycles) with a coherent LO-then-HI
// read scheme via per-counter shadow registers, a CTRL register
// (enable / clear) and a constant ID register.
//
// Register map, decoded from addr[5:2]:
//   0 MCYCLE_LO   1 MCYCLE_HI   2 MINSTRET_LO   3 MINSTRET_HI
//   4 STALL_LO    5 STALL_HI    6 CTRL          7 ID
//   8..15 unmapped (error response)
//
// Reading a LO word returns the counter's low half as it stood in the accept
// cycle and snapshots the high half into the shadow; reading HI returns the
// shadow, so a LO-then-HI pair is always coherent.
module tlm_mmio_slave #(
    parameter logic [31:0] ID_VALUE     = 32'h544C_4D01,
    parameter logic        RESET_ENABLE = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               retire_i,
    input  logic               stall_i,
    tlm_mmio_slave_if.slave    bus,
    output logic [63:0]        tlm_mcycle_o,
    output logic [63:0]        tlm_minstret_o,
    output logic [63:0]        tlm_stall_o,
    output logic               dbg_state
);

    localparam logic [2:0] OFF_MCYCLE_LO   = 3'd0;
    localparam logic [2:0] OFF_MCYCLE_HI   = 3'd1;
    localparam logic [2:0] OFF_MINSTRET_LO = 3'd2;
    localparam logic [2:0] OFF_MINSTRET_HI = 3'd3;
    localparam logic [2:0] OFF_STALL_LO    = 3'd4;
    localparam logic [2:0] OFF_STALL_HI    = 3'd5;
    localparam logic [2:0] OFF_CTRL        = 3'd6;
    localparam logic [2:0] OFF_ID          = 3'd7;

    // ST_IDLE: ready to accept; ST_RESP: response being presented.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] stall_cnt;
    logic [31:0] mcycle_shadow;
    logic [31:0] minstret_shadow;
    logic [31:0] stall_shadow;
    logic        enable;

    logic        req;
    logic        wr_req;
    logic        accept;
    logic        take;
    logic [3:0]  offset;
    logic        unmapped;
    logic        rd_wr_both;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        latch_mcycle;
    logic        latch_minstret;
    logic        latch_stall;
    logic        ctrl_wr;
    logic        ctrl_clear;

    logic [31:0] data_q;
    logic        error_q;
    logic [10:0] tag_q;

    // Address bits outside [5:2] and CTRL data bits above bit1 carry no meaning.
    logic        unused_bits;
    assign unused_bits = ^{bus.mem_addr_i[31:6], bus.mem_addr_i[1:0],
                           bus.mem_data_wr_i[31:2]};

    assign wr_req     = (bus.mem_wr_i != 4'd0);
    assign req        = bus.mem_rd_i || wr_req;
    assign offset     = bus.mem_addr_i[5:2];
    assign unmapped   = offset[3];
    assign rd_wr_both = bus.mem_rd_i && wr_req;
    assign take       = req && accept;

    // FSM state register; reset drops any in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and accept: one request in flight, response the cycle after.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = !rst_i;
                if (req && !rst_i) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request decode: read mux, shadow-latch strobes and CTRL write strobes.
    always_comb begin
        resp_data      = 32'd0;
        resp_err       = unmapped || rd_wr_both;
        latch_mcycle   = 1'b0;
        latch_minstret = 1'b0;
        latch_stall    = 1'b0;
        ctrl_wr        = 1'b0;
        ctrl_clear     = 1'b0;

        if (!resp_err && bus.mem_rd_i) begin
            case (offset[2:0])
                OFF_MCYCLE_LO:   resp_data = mcycle[31:0];
                OFF_MCYCLE_HI:   resp_data = mcycle_shadow;
                OFF_MINSTRET_LO: resp_data = minstret[31:0];
                OFF_MINSTRET_HI: resp_data = minstret_shadow;
                OFF_STALL_LO:    resp_data = stall_cnt[31:0];
                OFF_STALL_HI:    resp_data = stall_shadow;
                OFF_CTRL:        resp_data = {31'd0, enable};
                OFF_ID:          resp_data = ID_VALUE;
                default:         resp_data = 32'd0;
            endcase
        end

        if (take && !resp_err) begin
            if (bus.mem_rd_i) begin
                latch_mcycle   = (offset[2:0] == OFF_MCYCLE_LO);
                latch_minstret = (offset[2:0] == OFF_MINSTRET_LO);
                latch_stall    = (offset[2:0] == OFF_STALL_LO);
            end
            // Only the low byte lane holds CTRL's live bits.
            if (wr_req && (offset[2:0] == OFF_CTRL) && bus.mem_wr_i[0]) begin
                ctrl_wr    = 1'b1;
                ctrl_clear = bus.mem_data_wr_i[1];
            end
        end
    end

    // Counters, shadows and enable; clear beats increment, new enable applies next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle          <= 64'd0;
            minstret        <= 64'd0;
            stall_cnt       <= 64'd0;
            mcycle_shadow   <= 32'd0;
            minstret_shadow <= 32'd0;
            stall_shadow    <= 32'd0;
            enable          <= RESET_ENABLE;
        end else begin
            if (ctrl_wr) begin
                enable <= bus.mem_data_wr_i[0];
            end
            if (ctrl_clear) begin
                mcycle          <= 64'd0;
                minstret        <= 64'd0;
                stall_cnt       <= 64'd0;
                mcycle_shadow   <= 32'd0;
                minstret_shadow <= 32'd0;
                stall_shadow    <= 32'd0;
            end else begin
                if (enable) begin
                    mcycle    <= mcycle + 64'd1;
                    minstret  <= minstret + {63'd0, retire_i};
                    stall_cnt <= stall_cnt + {63'd0, stall_i};
                end
                if (latch_mcycle) begin
                    mcycle_shadow <= mcycle[63:32];
                end
                if (latch_minstret) begin
                    minstret_shadow <= minstret[63:32];
                end
                if (latch_stall) begin
                    stall_shadow <= stall_cnt[63:32];
                end
            end
        end
    end

    // Response registers, loaded only when a request is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= 32'd0;
            error_q <= 1'b0;
            tag_q   <= 11'd0;
        end else if (take) begin
            data_q  <= resp_data;
            error_q <= resp_err;
            tag_q   <= bus.mem_req_tag_i;
        end
    end

    // Ack is masked during reset so a response caught by reset is never seen.
    assign bus.mem_accept_o   = accept;
    assign bus.mem_ack_o      = (state == ST_RESP) && !rst_i;
    assign bus.mem_data_rd_o  = data_q;
    assign bus.mem_error_o    = error_q;
    assign bus.mem_resp_tag_o = tag_q;

    assign tlm_mcycle_o   = mcycle;
    assign tlm_minstret_o = minstret;
    assign tlm_stall_o    = stall_cnt;
    assign dbg_state      = state;

endmodule
